// File: rtl/rv32i_instruction_encoder.sv
// rtl/rv32i_instruction_encoder.sv - packs decoded RV32I fields into words and writes them to IMEM
module rv32i_instruction_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   instr_count,
  output logic              full,
  output logic              err_imm,
  output logic              err_fmt,
  output logic [ADDR_W:0]   err_index
);

  localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   DEPTH_M1 = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // S0 capture register
  logic        s0_valid;
  logic [2:0]  s0_fmt;
  logic [6:0]  s0_opcode;
  logic [4:0]  s0_rd;
  logic [4:0]  s0_rs1;
  logic [4:0]  s0_rs2;
  logic [2:0]  s0_func3;
  logic [6:0]  s0_func7;
  logic [31:0] s0_imm;

  logic signed [31:0] simm;
  logic               is_shift;
  logic [31:0]        word;
  logic               bad_imm;
  logic               bad_fmt;
  logic               accept;
  logic [ADDR_W-1:0]  ptr;

  // The last free slot may already be claimed by the instruction sitting in S0;
  // holding off one more accept there keeps the pointer from ever wrapping.
  assign in_ready = !full && !clear && !(s0_valid && instr_count == DEPTH_M1);
  assign accept   = in_valid && in_ready;
  assign full     = (instr_count == DEPTH_C);
  assign simm     = $signed(s0_imm);
  assign is_shift = (s0_opcode == 7'b0010011) && (s0_func3 == 3'b001 || s0_func3 == 3'b101);

  // Capture the field bundle on accept; clear drops whatever is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid  <= 1'b0;
      s0_fmt    <= '0;
      s0_opcode <= '0;
      s0_rd     <= '0;
      s0_rs1    <= '0;
      s0_rs2    <= '0;
      s0_func3  <= '0;
      s0_func7  <= '0;
      s0_imm    <= '0;
    end else if (clear) begin
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_fmt    <= fmt;
        s0_opcode <= opcode;
        s0_rd     <= rd;
        s0_rs1    <= rs1;
        s0_rs2    <= rs2;
        s0_func3  <= func3;
        s0_func7  <= func7;
        s0_imm    <= imm;
      end
    end
  end

  // Pack the captured fields and range-check the immediate for its format
  always_comb begin
    word    = '0;
    bad_imm = 1'b0;
    bad_fmt = 1'b0;
    case (s0_fmt)
      FMT_R: begin
        word = {s0_func7, s0_rs2, s0_rs1, s0_func3, s0_rd, s0_opcode};
      end
      FMT_I: begin
        if (is_shift) begin
          word    = {s0_func7, s0_imm[4:0], s0_rs1, s0_func3, s0_rd, s0_opcode};
          bad_imm = (simm < 0) || (simm > 31);
        end else begin
          word    = {s0_imm[11:0], s0_rs1, s0_func3, s0_rd, s0_opcode};
          bad_imm = (simm < -2048) || (simm > 2047);
        end
      end
      FMT_S: begin
        word    = {s0_imm[11:5], s0_rs2, s0_rs1, s0_func3, s0_imm[4:0], s0_opcode};
        bad_imm = (simm < -2048) || (simm > 2047);
      end
      FMT_B: begin
        word    = {s0_imm[12], s0_imm[10:5], s0_rs2, s0_rs1, s0_func3,
                   s0_imm[4:1], s0_imm[11], s0_opcode};
        bad_imm = (simm < -4096) || (simm > 4094) || s0_imm[0];
      end
      FMT_U: begin
        word    = {s0_imm[31:12], s0_rd, s0_opcode};
        bad_imm = (s0_imm[11:0] != 12'd0);
      end
      FMT_J: begin
        word    = {s0_imm[20], s0_imm[10:1], s0_imm[11], s0_imm[19:12], s0_rd, s0_opcode};
        bad_imm = (simm < -1048576) || (simm > 1048574) || s0_imm[0];
      end
      default: begin
        bad_fmt = 1'b1;
      end
    endcase
  end

  // S1: issue the IMEM write for legal words, otherwise record the sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ptr         <= BASE_C;
      instr_count <= '0;
      err_imm     <= 1'b0;
      err_fmt     <= 1'b0;
      err_index   <= '0;
    end else if (clear) begin
      mem_we      <= 1'b0;
      ptr         <= BASE_C;
      instr_count <= '0;
      err_imm     <= 1'b0;
      err_fmt     <= 1'b0;
      err_index   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (s0_valid) begin
        if (bad_fmt || bad_imm) begin
          if (bad_fmt) err_fmt <= 1'b1;
          if (bad_imm) err_imm <= 1'b1;
          if (!err_imm && !err_fmt) err_index <= instr_count;
        end else begin
          mem_we      <= 1'b1;
          mem_addr    <= ptr;
          mem_wdata   <= word;
          ptr         <= ptr + 1'b1;
          instr_count <= instr_count + 1'b1;
        end
      end
    end
  end

endmodule
